secure_access_ctrl: RTL and testbench
=====================================

Name: secure_access_ctrl

Overview:
Parametrised key-checked access controller between the register-file store/load path and data memory. It replaces fixed-width, single-key point-to-point security wiring with a per-region key table, a valid/ready request channel, a response channel with an error flag, and a brute-force lockout. It sits between registers (requester) and memory (single-port, 1-cycle read latency).

Parameters:
DATA_W, 32, data word width
ADDR_W, 10, word address width
KEY_W, 16, access key width
NUM_REGIONS, 4, power of two; region = req_addr[ADDR_W-1 -: log2(NUM_REGIONS)]
MAX_FAILS, 3, consecutive key failures that trigger lockout (>=1)
LOCK_CYCLES, 16, lockout duration in clk cycles (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_write  in  1  1=store, 0=load
req_addr  in  ADDR_W  target word address
req_wdata  in  DATA_W  store data
req_key  in  KEY_W  key presented with request
key_load  in  1  program key table this cycle
key_region  in  log2(NUM_REGIONS)  region being programmed
key_value  in  KEY_W  new key (0 = region disabled)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid cycle after mem_en&&!mem_we
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accepted
rsp_rdata  out  DATA_W  load data (0 on store or error)
rsp_err  out  1  access denied
locked  out  1  lockout active

Behaviour:
- Reset (async): state IDLE, all key entries 0, fail_cnt 0, lock_cnt 0; req_ready 1 once rst deasserts (0 during rst), all other outputs 0.
- FSM: IDLE, CHECK, ACCESS, RD_WAIT, RESP, LOCK. All outputs registered or decoded from state only.
- IDLE: req_ready=1. Handshake at cycle T latches write/addr/wdata/key -> CHECK.
- CHECK (T+1): pass iff key_table[region]!=0 and equals latched key. Pass -> ACCESS. Fail -> RESP with rsp_err=1, rsp_rdata=0, fail_cnt+1 (saturating at MAX_FAILS).
- ACCESS (T+2): mem_en=1 for exactly one cycle, mem_we=latched write, mem_addr/mem_wdata from latch. Store -> RESP; load -> RD_WAIT. fail_cnt cleared to 0.
- RD_WAIT (T+3): capture mem_rdata into rsp_rdata -> RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready. On handshake: if fail_cnt==MAX_FAILS -> LOCK (lock_cnt=LOCK_CYCLES-1), else -> IDLE. No new request accepted in the handshake cycle.
- First rsp_valid: error T+2, store T+3, load T+4; next request accepted earliest the cycle after rsp handshake.
- LOCK: locked=1, req_ready=0; decrement lock_cnt each cycle; at 0 -> IDLE, fail_cnt=0. Exactly LOCK_CYCLES cycles with locked=1.
- Key table: key_load writes key_table[key_region]=key_value at clock edge, in any state including LOCK. A CHECK in the same cycle as a key_load to its region uses the old value.
- Address passes unchanged; region bits only select key. No wrap arithmetic.
- rst asserted mid-transaction: transaction dropped, no mem_en, no response; key table cleared.

Decomposition:
- Package secure_pkg: FSM state enum, response error code constant, log2 helper/REGION_W localparam derivation.
- One sub-module natural: secure_key_table (NUM_REGIONS x KEY_W register array, one write port, one combinational read port, async-reset to 0).

Test Plan:
- Program region 0 key 16'hA5A5; store addr 10'h010 data 32'hDEADBEEF key A5A5 -> mem_en/mem_we at T+2, rsp_valid T+3, rsp_err=0; then load same addr -> rsp_rdata 32'hDEADBEEF at T+4.
- Load addr 10'h300 (region 3, key never programmed) key 16'h0000 -> rsp_err=1, no mem_en ever pulses, rsp_rdata 0.
- Three consecutive wrong-key requests to region 0 (MAX_FAILS=3) -> third response err, then locked=1 for exactly 16 cycles with req_ready=0; valid request at cycle 17 accepted.
- Two wrong keys then one correct -> fail_cnt resets; two further wrong keys do not lock.
- Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid/rsp_rdata stable, req_ready=0 throughout, no second mem_en.
- key_load region 0 to 16'h1234 in same cycle as CHECK with key A5A5 (old key) -> passes; next request with A5A5 -> rsp_err=1. Assert rst during ACCESS -> no response, key table reads 0.

Source files
------------

// File: rtl/secure_pkg.sv
// Shared types and helpers for the key-checked memory access controller.
package secure_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESP    = 3'd4,
    ST_LOCK    = 3'd5
  } state_e;

  localparam logic RSP_ERR_NONE   = 1'b0;
  localparam logic RSP_ERR_DENIED = 1'b1;

  // Bits needed to index n items; never returns 0 so vectors stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/secure_key_table.sv
// Per-region access key store: one write port, one combinational read port.
module secure_key_table
  import secure_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int KEY_W       = 16,
  parameter int REGION_W    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [REGION_W-1:0] waddr_i,
  input  logic [KEY_W-1:0]    wdata_i,
  input  logic [REGION_W-1:0] raddr_i,
  output logic [KEY_W-1:0]    rdata_o
);

  logic [KEY_W-1:0] key_q [NUM_REGIONS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGIONS; i++) key_q[i] <= '0;
    end else if (we_i) begin
      key_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge value, so a same-cycle write is not visible.
  assign rdata_o = key_q[raddr_i];

endmodule

// File: rtl/secure_access_ctrl.sv
// Key-checked access controller between the register file and a single-port
// data memory, with per-region keys and a brute-force lockout.
module secure_access_ctrl
  import secure_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int KEY_W       = 16,
  parameter int NUM_REGIONS = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16,
  localparam int REGION_W   = clog2_min1(NUM_REGIONS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [KEY_W-1:0]    req_key,
  input  logic                key_load,
  input  logic [REGION_W-1:0] key_region,
  input  logic [KEY_W-1:0]    key_value,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                locked,
  output logic [2:0]          dbg_state
);

  localparam int FAIL_W = clog2_min1(MAX_FAILS + 1);
  localparam int LOCK_W = clog2_min1(LOCK_CYCLES);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCK_CYCLES - 1);

  state_e              state_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [KEY_W-1:0]    key_q;
  logic [FAIL_W-1:0]   fail_cnt_q;
  logic [LOCK_W-1:0]   lock_cnt_q;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [KEY_W-1:0]    table_key;
  logic                key_ok_d;

  secure_key_table #(
    .NUM_REGIONS (NUM_REGIONS),
    .KEY_W       (KEY_W),
    .REGION_W    (REGION_W)
  ) u_key_table (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (key_load),
    .waddr_i (key_region),
    .wdata_i (key_value),
    .raddr_i (addr_q[ADDR_W-1 -: REGION_W]),
    .rdata_o (table_key)
  );

  // A zero table entry disables its region regardless of the presented key.
  assign key_ok_d = (table_key != '0) && (table_key == key_q);

  // Both channels transfer on a clock edge where valid && ready are high.
  // A request is held by the requester until accepted; a response is held
  // stable by this block until accepted.
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign locked    = (state_q == ST_LOCK);
  assign dbg_state = state_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      key_q       <= '0;
      fail_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= RSP_ERR_NONE;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            key_q   <= req_key;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (key_ok_d) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= write_q;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wdata_q;
            state_q     <= ST_ACCESS;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= RSP_ERR_DENIED;
            rsp_rdata_q <= '0;
            if (fail_cnt_q != FAIL_MAX) fail_cnt_q <= fail_cnt_q + 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_ACCESS: begin
          mem_en_q   <= 1'b0;
          mem_we_q   <= 1'b0;
          fail_cnt_q <= '0;
          if (write_q) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= RSP_ERR_NONE;
            rsp_rdata_q <= '0;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= RSP_ERR_NONE;
          rsp_rdata_q <= mem_rdata;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= RSP_ERR_NONE;
            rsp_rdata_q <= '0;
            if (fail_cnt_q == FAIL_MAX) begin
              lock_cnt_q <= LOCK_INIT;
              state_q    <= ST_LOCK;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_LOCK: begin
          if (lock_cnt_q == '0) begin
            fail_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_access_ctrl.sv
// Directed bench for secure_access_ctrl with a behavioural 1-cycle memory.
module tb_secure_access_ctrl;
  import secure_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int KEY_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [KEY_W-1:0]  req_key = '0;
  logic              key_load = 1'b0;
  logic [1:0]        key_region = '0;
  logic [KEY_W-1:0]  key_value = '0;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_err, locked;
  logic [DATA_W-1:0] rsp_rdata;
  logic [2:0]        dbg_state;

  int checks = 0;
  int failures = 0;
  int mem_en_cnt = 0;
  int c0, c1;

  logic [DATA_W-1:0] mem [1024];

  secure_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_key(req_key),
    .key_load(key_load), .key_region(key_region), .key_value(key_value),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .locked(locked), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      mem_en_cnt <= mem_en_cnt + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [1:0] r, input logic [KEY_W-1:0] v);
    key_load = 1'b1; key_region = r; key_value = v;
    tick();
    key_load = 1'b0;
  endtask

  // Leaves the caller one cycle after the request handshake (CHECK cycle).
  task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [KEY_W-1:0] k);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_key = k;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic err_req(input string tag, input logic [ADDR_W-1:0] a, input logic [KEY_W-1:0] k);
    send(1'b0, a, '0, k);
    tick();
    chk({tag, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_err"}, 64'(rsp_err), 64'(1));
    accept();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_locked", 64'(locked), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'(1));
    tick();

    // Store then load through region 0.
    load_key(2'd0, 16'hA5A5);
    c0 = mem_en_cnt;
    send(1'b1, 10'h010, 32'hDEADBEEF, 16'hA5A5);
    chk("st_check_state", 64'(dbg_state), 64'(ST_CHECK));
    chk("st_t1_no_en", 64'(mem_en), 64'(0));
    tick();
    chk("st_t2_en", 64'(mem_en), 64'(1));
    chk("st_t2_we", 64'(mem_we), 64'(1));
    chk("st_t2_addr", 64'(mem_addr), 64'(10'h010));
    chk("st_t2_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
    chk("st_t2_no_rsp", 64'(rsp_valid), 64'(0));
    tick();
    chk("st_t3_en_off", 64'(mem_en), 64'(0));
    chk("st_t3_valid", 64'(rsp_valid), 64'(1));
    chk("st_t3_err", 64'(rsp_err), 64'(0));
    chk("st_t3_rdata", 64'(rsp_rdata), 64'(0));
    accept();
    chk("st_done_ready", 64'(req_ready), 64'(1));
    chk("st_done_valid", 64'(rsp_valid), 64'(0));

    send(1'b0, 10'h010, '0, 16'hA5A5);
    tick();
    chk("ld_t2_en", 64'(mem_en), 64'(1));
    chk("ld_t2_we", 64'(mem_we), 64'(0));
    tick();
    chk("ld_t3_no_rsp", 64'(rsp_valid), 64'(0));
    tick();
    chk("ld_t4_valid", 64'(rsp_valid), 64'(1));
    chk("ld_t4_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    chk("ld_t4_err", 64'(rsp_err), 64'(0));
    c1 = mem_en_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
      chk("hold_ready", 64'(req_ready), 64'(0));
    end
    chk("hold_no_en", 64'(mem_en_cnt), 64'(c1));
    chk("two_en_pulses", 64'(mem_en_cnt), 64'(c0 + 2));
    accept();

    // Unprogrammed region 3: denied without touching memory.
    c0 = mem_en_cnt;
    send(1'b0, 10'h300, '0, 16'h0000);
    tick();
    chk("r3_valid", 64'(rsp_valid), 64'(1));
    chk("r3_err", 64'(rsp_err), 64'(1));
    chk("r3_rdata", 64'(rsp_rdata), 64'(0));
    accept();
    chk("r3_no_en", 64'(mem_en_cnt), 64'(c0));

    // Two failures then a pass clears the count.
    err_req("wrong1", 10'h010, 16'hBEEF);
    chk("wrong1_unlocked", 64'(locked), 64'(0));
    send(1'b1, 10'h011, 32'h11111111, 16'hA5A5);
    tick();
    tick();
    chk("good_valid", 64'(rsp_valid), 64'(1));
    chk("good_err", 64'(rsp_err), 64'(0));
    accept();
    err_req("wrong2a", 10'h010, 16'h0001);
    err_req("wrong2b", 10'h020, 16'h0002);
    chk("two_fail_unlocked", 64'(locked), 64'(0));
    chk("two_fail_ready", 64'(req_ready), 64'(1));

    // Third consecutive failure locks for exactly 16 cycles.
    err_req("wrong3", 10'h010, 16'h0003);
    c0 = mem_en_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h010; req_key = 16'hA5A5;
    for (int i = 0; i < 16; i++) begin
      chk("lock_on", 64'(locked), 64'(1));
      chk("lock_ready", 64'(req_ready), 64'(0));
      tick();
    end
    chk("lock_off", 64'(locked), 64'(0));
    chk("lock_off_ready", 64'(req_ready), 64'(1));
    send(1'b0, 10'h010, '0, 16'hA5A5);
    chk("lock_no_en", 64'(mem_en_cnt), 64'(c0));
    tick();
    tick();
    tick();
    chk("post_lock_valid", 64'(rsp_valid), 64'(1));
    chk("post_lock_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    accept();

    // Key reprogrammed during CHECK: the old key still applies.
    send(1'b0, 10'h010, '0, 16'hA5A5);
    key_load = 1'b1; key_region = 2'd0; key_value = 16'h1234;
    tick();
    key_load = 1'b0;
    chk("old_key_pass_en", 64'(mem_en), 64'(1));
    tick();
    tick();
    chk("old_key_valid", 64'(rsp_valid), 64'(1));
    chk("old_key_err", 64'(rsp_err), 64'(0));
    chk("old_key_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    accept();
    err_req("stale_key", 10'h010, 16'hA5A5);
    send(1'b1, 10'h020, 32'h12345678, 16'h1234);
    tick();
    chk("new_key_en", 64'(mem_en), 64'(1));
    tick();
    chk("new_key_valid", 64'(rsp_valid), 64'(1));
    chk("new_key_err", 64'(rsp_err), 64'(0));
    accept();

    // Reset in ACCESS drops the transaction and clears the key table.
    c0 = mem_en_cnt;
    send(1'b1, 10'h030, 32'hCAFEF00D, 16'h1234);
    tick();
    chk("pre_rst_state", 64'(dbg_state), 64'(ST_ACCESS));
    rst = 1'b1;
    #1;
    chk("mid_rst_en", 64'(mem_en), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    chk("rst_no_en", 64'(mem_en_cnt), 64'(c0));
    err_req("cleared_key", 10'h010, 16'h1234);
    err_req("zero_key", 10'h010, 16'h0000);
    chk("cleared_no_en", 64'(mem_en_cnt), 64'(c0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
